// File: rtl/csr_file.sv
// Machine-mode CSR register file and trap controller for the EX stage.
// Reads are combinational, writes and trap side effects commit at the rising edge.

package csr_file_pkg;
  // Bit 2 marks the immediate forms, so each *I form differs from its register form only in bit 2.
  typedef enum logic [2:0] {
    CsrNone = 3'd0,
    CsrRw   = 3'd1,
    CsrRs   = 3'd2,
    CsrRc   = 3'd3,
    CsrRwi  = 3'd5,
    CsrRsi  = 3'd6,
    CsrRci  = 3'd7
  } csr_op_t;
endpackage

module csr_file
  import csr_file_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] MISA_VAL    = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  input  logic [31:0] ex_pc_i,
  input  logic [11:0] csr_addr_i,
  input  csr_op_t     csr_op_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  output logic        csr_illegal_o,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        mret_i,
  input  logic        irq_i,
  input  logic        retire_i,
  output logic        trap_taken_o,
  output logic [31:0] trap_target_o
);

  // Architectural state; mtvec/mepc keep only the word-aligned bits.
  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic        meie_q, meie_d;
  logic [29:0] mtvec_q, mtvec_d;
  logic [29:0] mepc_q, mepc_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;

  logic [31:0] rd_val;
  logic        mapped;
  logic        op_rw, op_rs, op_rc, is_write, illegal;
  logic [31:0] wr_val;
  logic        wr_en;
  logic        irq_take, exc_take, mret_take, trap_any;

  // Read mux: pre-write value of the addressed CSR, plus whether the address exists.
  always_comb begin
    rd_val = 32'd0;
    mapped = 1'b1;
    case (csr_addr_i)
      12'h300: rd_val = {19'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_q, 3'd0};
      12'h301: rd_val = MISA_VAL;
      12'h304: rd_val = {20'd0, meie_q, 11'd0};
      12'h305: rd_val = {mtvec_q, 2'b00};
      12'h340: rd_val = mscratch_q;
      12'h341: rd_val = {mepc_q, 2'b00};
      12'h342: rd_val = mcause_q;
      12'h343: rd_val = mtval_q;
      12'h344: rd_val = {20'd0, irq_i, 11'd0};
      12'hB00: rd_val = mcycle_q[31:0];
      12'hB80: rd_val = mcycle_q[63:32];
      12'hB02: rd_val = minstret_q[31:0];
      12'hB82: rd_val = minstret_q[63:32];
      12'hF14: rd_val = HART_ID;
      default: mapped = 1'b0;
    endcase
  end

  // Op decode, legality and the value a write would commit.
  always_comb begin
    op_rw    = (csr_op_i == CsrRw) || (csr_op_i == CsrRwi);
    op_rs    = (csr_op_i == CsrRs) || (csr_op_i == CsrRsi);
    op_rc    = (csr_op_i == CsrRc) || (csr_op_i == CsrRci);
    // Set/clear with a zero mask is a pure read and may target read-only CSRs.
    is_write = op_rw || ((op_rs || op_rc) && (csr_wdata_i != 32'd0));
    illegal  = (csr_op_i != CsrNone) &&
               (!mapped || (is_write && (csr_addr_i[11:10] == 2'b11)));
    wr_val   = csr_wdata_i;
    if (op_rs) wr_val = rd_val | csr_wdata_i;
    if (op_rc) wr_val = rd_val & ~csr_wdata_i;
  end

  // Trap arbitration: interrupt, then ecall/ebreak, then mret; at most one per cycle.
  always_comb begin
    irq_take  = ex_valid_i && mie_q && meie_q && irq_i;
    exc_take  = !irq_take && (ecall_i || ebreak_i);
    mret_take = !irq_take && !ecall_i && !ebreak_i && mret_i;
    trap_any  = irq_take || exc_take || mret_take;
    wr_en     = is_write && !illegal && !trap_any;
  end

  // Outputs are forced quiet while reset is asserted.
  always_comb begin
    csr_rdata_o   = 32'd0;
    csr_illegal_o = 1'b0;
    trap_taken_o  = 1'b0;
    trap_target_o = 32'd0;
    if (!rst) begin
      csr_rdata_o   = mapped ? rd_val : 32'd0;
      csr_illegal_o = illegal;
      trap_taken_o  = trap_any;
      if (irq_take || exc_take) trap_target_o = {mtvec_q, 2'b00};
      else if (mret_take)       trap_target_o = {mepc_q, 2'b00};
    end
  end

  // Next state: counters tick, then a CSR write, then trap side effects.
  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    meie_d     = meie_q;
    mtvec_d    = mtvec_q;
    mepc_d     = mepc_q;
    mscratch_d = mscratch_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = retire_i ? minstret_q + 64'd1 : minstret_q;

    if (wr_en) begin
      case (csr_addr_i)
        12'h300: begin
          mie_d  = wr_val[3];
          mpie_d = wr_val[7];
        end
        12'h304: meie_d     = wr_val[11];
        12'h305: mtvec_d    = wr_val[31:2];
        12'h340: mscratch_d = wr_val;
        12'h341: mepc_d     = wr_val[31:2];
        12'h342: mcause_d   = wr_val;
        12'h343: mtval_d    = wr_val;
        // A write to one half replaces the increment; the other half holds, no carry.
        12'hB00: mcycle_d   = {mcycle_q[63:32], wr_val};
        12'hB80: mcycle_d   = {wr_val, mcycle_q[31:0]};
        12'hB02: minstret_d = {minstret_q[63:32], wr_val};
        12'hB82: minstret_d = {wr_val, minstret_q[31:0]};
        default: ;
      endcase
    end

    if (irq_take) begin
      mepc_d   = ex_pc_i[31:2];
      mcause_d = 32'h8000_000B;
      mtval_d  = 32'd0;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (exc_take) begin
      mepc_d   = ex_pc_i[31:2];
      mcause_d = ecall_i ? 32'd11 : 32'd3;
      mtval_d  = ecall_i ? 32'd0 : ex_pc_i;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret_take) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end
  end

  // State register; synchronous reset overrides every pending update.
  always_ff @(posedge clk) begin
    if (rst) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      meie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RESET[31:2];
      mepc_q     <= 30'd0;
      mscratch_q <= 32'd0;
      mcause_q   <= 32'd0;
      mtval_q    <= 32'd0;
      mcycle_q   <= 64'd0;
      minstret_q <= 64'd0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      meie_q     <= meie_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mscratch_q <= mscratch_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  // MTVEC_RESET low bits are always dropped (direct mode).
  logic unused_reset_bits;
  assign unused_reset_bits = ^MTVEC_RESET[1:0];

endmodule
